// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store engine.
// Imported by mem_align and mem_access_unit.
package mem_access_unit_pkg;

  localparam logic [1:0] DRAM_NONE  = 2'b00;
  localparam logic [1:0] DRAM_LOAD  = 2'b01;
  localparam logic [1:0] DRAM_STORE = 2'b10;

  localparam logic [1:0] AM_BYTE = 2'b00;
  localparam logic [1:0] AM_HALF = 2'b01;
  localparam logic [1:0] AM_WORD = 2'b10;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  // Mode 11 behaves as word.
  function automatic logic is_misaligned(
    input logic [1:0] mode,
    input logic [1:0] off
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (mode == AM_BYTE): r = 1'b0;
      (mode == AM_HALF): r = off[0];
      default:           r = |off;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extract/extend for loads.
// Purely combinational.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  st_mode,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_mode,
  input  logic [1:0]  ld_off,
  input  logic        ld_sext,
  input  logic [31:0] rdata,
  output logic [31:0] ld_ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    wstrb = 4'b1111;
    wdata = st_data;
    unique case (1'b1)
      (st_mode == AM_BYTE): begin
        wstrb = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      (st_mode == AM_HALF): begin
        wstrb = 4'b0011 << {st_off[1], 1'b0};
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    b = rdata[{ld_off, 3'b000} +: 8];
    h = rdata[{ld_off[1], 4'b0000} +: 16];
    ld_ext = rdata;
    unique case (1'b1)
      (ld_mode == AM_BYTE):
        ld_ext = {{24{ld_sext & b[7]}}, b};
      (ld_mode == AM_HALF):
        ld_ext = {{16{ld_sext & h[15]}}, h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: req/ack bus master with
// pipeline stall, misalign detection and bus timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [1:0]  dram_sel,
  input  logic [1:0]  addr_mode,
  input  logic        sext_op,
  input  logic [31:0] alu_c,
  input  logic [31:0] rf_rD2,
  input  logic        flush,
  output logic        stall,
  output logic        mem_done,
  output logic [31:0] ld_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      mode_q, mode_d;
  logic            sext_q, sext_d;
  logic            we_q, we_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     ld_q, ld_d;
  logic            err_q, err_d;

  logic        is_ld, is_st, go, mis;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_ld;

  mem_align u_align (
    .st_mode (addr_mode),
    .st_off  (alu_c[1:0]),
    .st_data (rf_rD2),
    .wstrb   (al_wstrb),
    .wdata   (al_wdata),
    .ld_mode (mode_q),
    .ld_off  (off_q),
    .ld_sext (sext_q),
    .rdata   (bus_rdata),
    .ld_ext  (al_ld)
  );

  // rst_n gates go so every output reads 0 while in reset.
  assign is_ld = (dram_sel == DRAM_LOAD);
  assign is_st = (dram_sel == DRAM_STORE);
  assign go    = rst_n & mem_valid & (is_ld | is_st) & ~flush;
  assign mis   = is_misaligned(addr_mode, alu_c[1:0]);

  assign misalign  = (state_q == S_IDLE) & go & mis;
  assign stall     = ((state_q == S_IDLE) & go & ~mis)
                   | (state_q == S_REQ);
  assign bus_req   = (state_q == S_REQ);
  assign mem_done  = (state_q == S_DONE);
  assign bus_err   = (state_q == S_DONE) & err_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;
  assign ld_data   = ld_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    off_d   = off_q;
    mode_d  = mode_q;
    sext_d  = sext_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (go && !mis) begin
          addr_d  = {alu_c[31:2], 2'b00};
          off_d   = alu_c[1:0];
          mode_d  = addr_mode;
          sext_d  = sext_op;
          we_d    = is_st;
          wstrb_d = is_st ? al_wstrb : 4'b0000;
          wdata_d = is_st ? al_wdata : 32'd0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + TO_W'(1);
        if (bus_ack) begin
          ld_d    = we_q ? 32'd0 : al_ld;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          ld_d    = 32'd0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      mode_q  <= '0;
      sext_q  <= 1'b0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      mode_q  <= mode_d;
      sext_q  <= sext_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (TIMEOUT=4).
// Vector table plus hand sequences; completions via scoreboard.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic [1:0]  dram_sel = 2'b00;
  logic [1:0]  addr_mode = 2'b00;
  logic        sext_op = 1'b0;
  logic [31:0] alu_c = '0;
  logic [31:0] rf_rD2 = '0;
  logic        flush = 1'b0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stall, mem_done, misalign, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] ld_data, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  mem_access_unit #(.TIMEOUT(4), .TO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid),
    .dram_sel(dram_sel), .addr_mode(addr_mode),
    .sext_op(sext_op), .alu_c(alu_c), .rf_rD2(rf_rD2),
    .flush(flush), .stall(stall), .mem_done(mem_done),
    .ld_data(ld_data), .misalign(misalign),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ld;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  mode;
    logic        sext;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rdata;
    int          waits;
    logic        mis;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] ld;
  } vec_t;
  vec_t v[13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mem_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        e = sb.pop_front();
        chk("sb_ld_data", ld_data, e.ld);
        chk("sb_bus_err", {31'd0, bus_err}, {31'd0, e.err});
      end
    end
    if (rst_n && bus_err && !mem_done) begin
      checks++;
      errors++;
      $display("FAIL lone_bus_err: got 1 expected 0");
    end
  end

  task automatic issue(input logic [1:0] sel,
                       input logic [1:0] mode,
                       input logic sext,
                       input logic [31:0] a,
                       input logic [31:0] d);
    mem_valid = 1'b1;
    dram_sel  = sel;
    addr_mode = mode;
    sext_op   = sext;
    alu_c     = a;
    rf_rD2    = d;
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    issue(t.sel, t.mode, t.sext, t.a, t.d);
    #1;
    chk({p, "_misalign"}, {31'd0, misalign}, {31'd0, t.mis});
    chk({p, "_stall0"}, {31'd0, stall}, {31'd0, !t.mis});
    if (!t.mis) sb.push_back('{ld: t.ld, err: 1'b0});
    step();
    mem_valid = 1'b0;
    dram_sel  = DRAM_NONE;
    if (t.mis) begin
      chk({p, "_noreq"}, {31'd0, bus_req}, 32'd0);
      chk({p, "_nostall"}, {31'd0, stall}, 32'd0);
      return;
    end
    chk({p, "_addr"}, bus_addr, {t.a[31:2], 2'b00});
    chk({p, "_we"}, {31'd0, bus_we},
        {31'd0, t.sel == DRAM_STORE});
    chk({p, "_wstrb"}, {28'd0, bus_wstrb}, {28'd0, t.wstrb});
    if (t.sel == DRAM_STORE)
      chk({p, "_wdata"}, bus_wdata, t.wdata);
    for (int w = 0; w <= t.waits; w++) begin
      chk({p, "_req"}, {31'd0, bus_req}, 32'd1);
      chk({p, "_stall"}, {31'd0, stall}, 32'd1);
      if (w == t.waits) begin
        bus_ack   = 1'b1;
        bus_rdata = t.rdata;
      end
      step();
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
    end
    chk({p, "_done"}, {31'd0, mem_done}, 32'd1);
    chk({p, "_done_stall"}, {31'd0, stall}, 32'd0);
    chk({p, "_done_req"}, {31'd0, bus_req}, 32'd0);
    step();
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, "_req"}, {31'd0, bus_req}, 32'd0);
    chk({p, "_stall"}, {31'd0, stall}, 32'd0);
    chk({p, "_done"}, {31'd0, mem_done}, 32'd0);
    chk({p, "_err"}, {31'd0, bus_err}, 32'd0);
    chk({p, "_mis"}, {31'd0, misalign}, 32'd0);
    chk({p, "_we"}, {31'd0, bus_we}, 32'd0);
    chk({p, "_ld"}, ld_data, 32'd0);
    chk({p, "_addr"}, bus_addr, 32'd0);
    chk({p, "_wstrb"}, {28'd0, bus_wstrb}, 32'd0);
    chk({p, "_wdata"}, bus_wdata, 32'd0);
  endtask

  initial begin
    int n;
    v[0]  = '{DRAM_STORE, AM_BYTE, 1'b0, 32'h1003, 32'h000000A5,
              32'h0, 0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
    v[1]  = '{DRAM_LOAD, AM_HALF, 1'b1, 32'h2002, 32'h0,
              32'h80FF1234, 0, 1'b0, 4'b0000, 32'h0, 32'hFFFF80FF};
    v[2]  = '{DRAM_LOAD, AM_HALF, 1'b0, 32'h2002, 32'h0,
              32'h80FF1234, 0, 1'b0, 4'b0000, 32'h0, 32'h000080FF};
    v[3]  = '{DRAM_LOAD, AM_WORD, 1'b0, 32'h3001, 32'h0,
              32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    v[4]  = '{DRAM_LOAD, AM_BYTE, 1'b1, 32'h4001, 32'h0,
              32'h11228344, 1, 1'b0, 4'b0000, 32'h0, 32'hFFFFFF83};
    v[5]  = '{DRAM_LOAD, AM_BYTE, 1'b0, 32'h4000, 32'h0,
              32'h11228344, 0, 1'b0, 4'b0000, 32'h0, 32'h00000044};
    v[6]  = '{DRAM_LOAD, AM_WORD, 1'b1, 32'h5004, 32'h0,
              32'hDEADBEEF, 2, 1'b0, 4'b0000, 32'h0, 32'hDEADBEEF};
    v[7]  = '{DRAM_STORE, AM_HALF, 1'b0, 32'h6002, 32'h1234ABCD,
              32'h0, 1, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
    v[8]  = '{DRAM_STORE, AM_WORD, 1'b0, 32'h7000, 32'hCAFEF00D,
              32'h0, 0, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
    v[9]  = '{DRAM_STORE, AM_HALF, 1'b0, 32'h6001, 32'h1234,
              32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    v[10] = '{DRAM_LOAD, AM_HALF, 1'b1, 32'h2000, 32'h0,
              32'h80FF1234, 0, 1'b0, 4'b0000, 32'h0, 32'h00001234};
    v[11] = '{DRAM_STORE, AM_BYTE, 1'b0, 32'h1001, 32'h0000005A,
              32'h0, 0, 1'b0, 4'b0010, 32'h5A5A5A5A, 32'h0};
    v[12] = '{DRAM_LOAD, 2'b11, 1'b0, 32'h8000, 32'h0,
              32'h12345678, 0, 1'b0, 4'b0000, 32'h0, 32'h12345678};

    // reset state
    #2;
    chk_all_zero("rst");
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 13; i++) run_vec(v[i], i);

    // timeout: ack withheld, TIMEOUT=4
    issue(DRAM_LOAD, AM_WORD, 1'b0, 32'h9000, 32'h0);
    sb.push_back('{ld: 32'h0, err: 1'b1});
    step();
    mem_valid = 1'b0;
    n = 0;
    while (bus_req && n < 20) begin
      n++;
      step();
    end
    chk("to_req_cycles", n, 32'd4);
    chk("to_done", {31'd0, mem_done}, 32'd1);
    chk("to_err", {31'd0, bus_err}, 32'd1);
    chk("to_ld", ld_data, 32'd0);
    step();

    // reset during REQ after 2 wait states
    run_vec(v[6], 100);
    issue(DRAM_LOAD, AM_WORD, 1'b0, 32'hA000, 32'h0);
    sb.push_back('{ld: 32'h0, err: 1'b0});
    step();
    mem_valid = 1'b0;
    step();
    step();
    chk("rr_req_before", {31'd0, bus_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rr");
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("rr_idle_done", {31'd0, mem_done}, 32'd0);
    run_vec(v[1], 101);

    // stray ack in IDLE
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("stray_ack_req", {31'd0, bus_req}, 32'd0);
    step();

    // flush in IDLE drops the op
    issue(DRAM_LOAD, AM_WORD, 1'b0, 32'hB000, 32'h0);
    flush = 1'b1;
    #1;
    chk("fl_idle_stall", {31'd0, stall}, 32'd0);
    step();
    mem_valid = 1'b0;
    flush = 1'b0;
    chk("fl_idle_req", {31'd0, bus_req}, 32'd0);
    step();

    // flush during REQ is ignored
    issue(DRAM_LOAD, AM_WORD, 1'b0, 32'hB004, 32'h0);
    sb.push_back('{ld: 32'h0BADF00D, err: 1'b0});
    step();
    mem_valid = 1'b0;
    flush = 1'b1;
    chk("fl_req_req", {31'd0, bus_req}, 32'd1);
    step();
    chk("fl_req_hold", {31'd0, bus_req}, 32'd1);
    bus_ack = 1'b1;
    bus_rdata = 32'h0BADF00D;
    step();
    bus_ack = 1'b0;
    flush = 1'b0;
    chk("fl_req_done", {31'd0, mem_done}, 32'd1);
    step();
    step();

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

endmodule
